vga_ball_renderer: RTL and testbench

Pixel-generation stage directly downstream of the VGA sync generator. It consumes that block's `CounterX`, `CounterY`, `inDisplayArea` and `vga_v_sync` and produces a registered 3-bit RGB value per pixel. The output draws a square ball on a solid background. The ball's position advances once per frame and reflects off the screen edges, with one direction state machine per axis.

---
 rtl/vga_ball_renderer.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_ball_renderer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_ball_renderer.sv
// ---------------------------------------------------------------------------
// vga_ball_renderer
//
// Pixel stage placed after the VGA sync generator. Draws a square ball on a
// solid background and moves the ball once per frame. Each axis has its own
// two-state direction FSM (INC/DEC) that reflects the ball off the screen
// edges.
//
// Optional feature (compile-time macro):
//   BALL_BORDER_EN  - when defined, the outermost visible rows/columns are
//                     drawn white (3'b111). The ball has higher priority than
//                     the border. When undefined, no border logic exists and
//                     those pixels show the background colour.
//
// Ports:
//   clk            in   1   pixel/system clock (same as the sync generator)
//   Reset          in   1   asynchronous, active-high reset
//   CounterX       in  10   current pixel column
//   CounterY       in   9   current pixel row
//   inDisplayArea  in   1   high while the current pixel is visible
//   vga_v_sync     in   1   vertical sync, active low
//   pause          in   1   freezes ball motion (sampled on the frame tick)
//   vga_rgb        out  3   registered {R,G,B}, 1 clk after the counters
//   frame_count    out  8   frames seen since reset, wraps at 255
//   bounce         out  1   one-clk pulse after a tick with any reflection
//   dbgBallX       out 10   debug: current ball column
//   dbgBallY       out  9   debug: current ball row
//   dbgXDir        out  1   debug: X FSM state (0 = INC, 1 = DEC)
//   dbgYDir        out  1   debug: Y FSM state (0 = INC, 1 = DEC)
// ---------------------------------------------------------------------------
module vga_ball_renderer #(
    parameter int         H_ACTIVE  = 640,
    parameter int         V_ACTIVE  = 480,
    parameter int         BALL_SIZE = 16,
    parameter int         STEP      = 2,
    parameter logic [2:0] BALL_RGB  = 3'b100,
    parameter logic [2:0] BG_RGB    = 3'b001
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [9:0] CounterX,
    input  logic [8:0] CounterY,
    input  logic       inDisplayArea,
    input  logic       vga_v_sync,
    input  logic       pause,
    output logic [2:0] vga_rgb,
    output logic [7:0] frame_count,
    output logic       bounce,
    output logic [9:0] dbgBallX,
    output logic [8:0] dbgBallY,
    output logic       dbgXDir,
    output logic       dbgYDir
);

    typedef enum logic {
        INC = 1'b0,
        DEC = 1'b1
    } dir_t;

    // All position arithmetic is done in 11 bits so pos+STEP and
    // pos+BALL_SIZE can never wrap.
    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  X_MAX10 = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [8:0]  Y_MAX9  = 9'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] SIZE11  = 11'(BALL_SIZE);
    localparam logic [9:0]  X_START = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [8:0]  Y_START = 9'((V_ACTIVE - BALL_SIZE) / 2);

    // ------------------------------------------------------------------
    // Frame tick: falling edge of vsync. vsyncD resets high.
    // ------------------------------------------------------------------
    logic vsyncD;
    logic tick;
    logic move;

    assign tick = vsyncD & ~vga_v_sync;
    assign move = tick & ~pause;

    // ------------------------------------------------------------------
    // Direction FSMs and position registers
    // ------------------------------------------------------------------
    dir_t        xState, xStateNext;
    dir_t        yState, yStateNext;
    logic [9:0]  ballX, ballXNext;
    logic [8:0]  ballY, ballYNext;
    logic        xReflect, yReflect;

    logic [10:0] xExt, xSum, xDiff;
    logic [10:0] yExt, ySum, yDiff;

    assign xExt  = {1'b0, ballX};
    assign xSum  = xExt + STEP11;
    assign xDiff = xExt - STEP11;
    assign yExt  = {2'b00, ballY};
    assign ySum  = yExt + STEP11;
    assign yDiff = yExt - STEP11;

    always_comb begin
        xStateNext = xState;
        ballXNext  = ballX;
        xReflect   = 1'b0;
        if (move) begin
            case (xState)
                INC: begin
                    if (xSum >= X_MAX) begin
                        ballXNext  = X_MAX10;
                        xStateNext = DEC;
                        xReflect   = 1'b1;
                    end else begin
                        ballXNext = xSum[9:0];
                    end
                end
                DEC: begin
                    if (xExt <= STEP11) begin
                        ballXNext  = '0;
                        xStateNext = INC;
                        xReflect   = 1'b1;
                    end else begin
                        ballXNext = xDiff[9:0];
                    end
                end
                default: xStateNext = INC;
            endcase
        end
    end

    always_comb begin
        yStateNext = yState;
        ballYNext  = ballY;
        yReflect   = 1'b0;
        if (move) begin
            case (yState)
                INC: begin
                    if (ySum >= Y_MAX) begin
                        ballYNext  = Y_MAX9;
                        yStateNext = DEC;
                        yReflect   = 1'b1;
                    end else begin
                        ballYNext = ySum[8:0];
                    end
                end
                DEC: begin
                    if (yExt <= STEP11) begin
                        ballYNext  = '0;
                        yStateNext = INC;
                        yReflect   = 1'b1;
                    end else begin
                        ballYNext = yDiff[8:0];
                    end
                end
                default: yStateNext = INC;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel colour
    // ------------------------------------------------------------------
    logic [10:0] cx, cy;
    logic        inBall;
    logic [2:0]  pixelColor;

    assign cx = {1'b0, CounterX};
    assign cy = {2'b00, CounterY};

    assign inBall = (cx >= xExt) && (cx < xExt + SIZE11) &&
                    (cy >= yExt) && (cy < yExt + SIZE11);

`ifdef BALL_BORDER_EN
    logic onBorder;
    assign onBorder = (CounterX == 10'd0) || (CounterX == 10'(H_ACTIVE - 1)) ||
                      (CounterY == 9'd0)  || (CounterY == 9'(V_ACTIVE - 1));

    always_comb begin
        pixelColor = BG_RGB;
        if (!inDisplayArea) begin
            pixelColor = 3'b000;
        end else if (inBall) begin
            pixelColor = BALL_RGB;
        end else if (onBorder) begin
            pixelColor = 3'b111;
        end
    end
`else
    always_comb begin
        pixelColor = BG_RGB;
        if (!inDisplayArea) begin
            pixelColor = 3'b000;
        end else if (inBall) begin
            pixelColor = BALL_RGB;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            vsyncD      <= 1'b1;
            xState      <= INC;
            yState      <= INC;
            ballX       <= X_START;
            ballY       <= Y_START;
            vga_rgb     <= 3'b000;
            frame_count <= 8'd0;
            bounce      <= 1'b0;
        end else begin
            vsyncD  <= vga_v_sync;
            xState  <= xStateNext;
            yState  <= yStateNext;
            ballX   <= ballXNext;
            ballY   <= ballYNext;
            vga_rgb <= pixelColor;
            // Frames are counted even while paused.
            if (tick) begin
                frame_count <= frame_count + 8'd1;
            end
            // A simultaneous reflection on both axes is still one pulse.
            bounce <= xReflect | yReflect;
        end
    end

    assign dbgBallX = ballX;
    assign dbgBallY = ballY;
    assign dbgXDir  = (xState == DEC);
    assign dbgYDir  = (yState == DEC);

endmodule

// File: tb/tb_vga_ball_renderer.sv
module tb_vga_ball_renderer;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       Reset;
    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       inDisplayArea;
    logic       vga_v_sync;
    logic       pause;
    logic [2:0] vga_rgb;
    logic [7:0] frame_count;
    logic       bounce;
    logic [9:0] dbgBallX;
    logic [8:0] dbgBallY;
    logic       dbgXDir;
    logic       dbgYDir;

    always #5 clk = ~clk;

    vga_ball_renderer dut (
        .clk(clk),
        .Reset(Reset),
        .CounterX(CounterX),
        .CounterY(CounterY),
        .inDisplayArea(inDisplayArea),
        .vga_v_sync(vga_v_sync),
        .pause(pause),
        .vga_rgb(vga_rgb),
        .frame_count(frame_count),
        .bounce(bounce),
        .dbgBallX(dbgBallX),
        .dbgBallY(dbgBallY),
        .dbgXDir(dbgXDir),
        .dbgYDir(dbgYDir)
    );

`ifdef BALL_BORDER_EN
    localparam logic [2:0] BORDER_EXP = 3'b111;
`else
    localparam logic [2:0] BORDER_EXP = 3'b001;
`endif

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;
    int bounce_seen = 0;
    logic [2:0] exp_q[$];

    // Pulses are sampled away from the active edge; one-cycle pulse => one count.
    always @(negedge clk) begin
        if (bounce) bounce_seen++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic apply_reset();
        @(negedge clk);
        Reset = 1'b1;
        vga_v_sync = 1'b1;
        pause = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge clk);
        vga_v_sync = 1'b0;
        @(negedge clk);
        vga_v_sync = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Drive one pixel and compare vga_rgb one clk later against exp_q.
    task automatic pixel(input string name, input logic [9:0] x, input logic [8:0] y,
                         input logic de, input logic [2:0] exp);
        logic [2:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        CounterX = x;
        CounterY = y;
        inDisplayArea = de;
        @(negedge clk);
        e = exp_q.pop_front();
        check(name, int'(vga_rgb), int'(e));
    endtask

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic       de;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   base;

    initial begin
        // Ball at reset covers columns 312..327, rows 232..247.
        vecs[0]  = '{x: 10'd320, y: 9'd240, de: 1'b1, exp: 3'b100};
        vecs[1]  = '{x: 10'd100, y: 9'd240, de: 1'b1, exp: 3'b001};
        vecs[2]  = '{x: 10'd320, y: 9'd240, de: 1'b0, exp: 3'b000};
        vecs[3]  = '{x: 10'd312, y: 9'd232, de: 1'b1, exp: 3'b100};
        vecs[4]  = '{x: 10'd327, y: 9'd247, de: 1'b1, exp: 3'b100};
        vecs[5]  = '{x: 10'd311, y: 9'd240, de: 1'b1, exp: 3'b001};
        vecs[6]  = '{x: 10'd328, y: 9'd240, de: 1'b1, exp: 3'b001};
        vecs[7]  = '{x: 10'd320, y: 9'd231, de: 1'b1, exp: 3'b001};
        vecs[8]  = '{x: 10'd320, y: 9'd248, de: 1'b1, exp: 3'b001};
        vecs[9]  = '{x: 10'd0,   y: 9'd0,   de: 1'b1, exp: BORDER_EXP};
        vecs[10] = '{x: 10'd639, y: 9'd479, de: 1'b1, exp: BORDER_EXP};
        vecs[11] = '{x: 10'd320, y: 9'd0,   de: 1'b1, exp: BORDER_EXP};

        Reset = 1'b1;
        CounterX = 10'd0;
        CounterY = 9'd0;
        inDisplayArea = 1'b0;
        vga_v_sync = 1'b1;
        pause = 1'b0;
        apply_reset();

        // Reset state
        check("reset_rgb", int'(vga_rgb), 0);
        check("reset_frame", int'(frame_count), 0);
        check("reset_ball_x", int'(dbgBallX), 312);
        check("reset_ball_y", int'(dbgBallY), 232);
        check("reset_xdir", int'(dbgXDir), 0);
        check("reset_ydir", int'(dbgYDir), 0);

        // Pixel vectors at the reset position
        for (int i = 0; i < 12; i++) begin
            pixel($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].exp);
        end

        // Asynchronous reset mid-line
        do_ticks(3);
        pixel("pre_reset_rgb", 10'd330, 9'd250, 1'b1, 3'b100);
        check("pre_reset_frame", int'(frame_count), 3);
        #2 Reset = 1'b1;
        #1;
        check("async_reset_rgb", int'(vga_rgb), 0);
        check("async_reset_frame", int'(frame_count), 0);
        check("async_reset_x", int'(dbgBallX), 312);
        @(negedge clk);
        Reset = 1'b0;

        // Motion: 10 ticks
        do_ticks(10);
        check("motion_x", int'(dbgBallX), 332);
        check("motion_y", int'(dbgBallY), 252);
        check("motion_frame", int'(frame_count), 10);
        pixel("motion_bg", 10'd331, 9'd251, 1'b1, 3'b001);
        pixel("motion_ball", 10'd332, 9'd252, 1'b1, 3'b100);

        // Bounce sequence from reset
        apply_reset();
        base = bounce_seen;
        do_ticks(115);
        check("pre_ybounce_y", int'(dbgBallY), 462);
        check("pre_ybounce_cnt", bounce_seen - base, 0);
        do_tick();
        check("ybounce_y", int'(dbgBallY), 464);
        check("ybounce_dir", int'(dbgYDir), 1);
        check("ybounce_cnt", bounce_seen - base, 1);
        do_ticks(39);
        check("pre_xbounce_x", int'(dbgBallX), 622);
        check("pre_xbounce_cnt", bounce_seen - base, 1);
        do_tick();
        check("xbounce_x", int'(dbgBallX), 624);
        check("xbounce_dir", int'(dbgXDir), 1);
        check("xbounce_y", int'(dbgBallY), 384);
        check("xbounce_cnt", bounce_seen - base, 2);
        check("xbounce_frame", int'(frame_count), 156);

        // Pause across 5 ticks
        pause = 1'b1;
        do_ticks(5);
        pause = 1'b0;
        check("pause_x", int'(dbgBallX), 624);
        check("pause_y", int'(dbgBallY), 384);
        check("pause_frame", int'(frame_count), 161);
        check("pause_cnt", bounce_seen - base, 2);

        // Pause toggled away from the tick has no effect
        @(negedge clk) pause = 1'b1;
        @(negedge clk);
        @(negedge clk) pause = 1'b0;
        do_tick();
        check("midpause_x", int'(dbgBallX), 622);
        check("midpause_y", int'(dbgBallY), 382);
        check("midpause_cnt", bounce_seen - base, 2);

        // Frame counter wrap and border pixel
        apply_reset();
        do_ticks(255);
        check("frame_255", int'(frame_count), 255);
        do_tick();
        check("frame_wrap", int'(frame_count), 0);
        check("wrap_x", int'(dbgBallX), 424);
        check("wrap_y", int'(dbgBallY), 184);
        pixel("border_00", 10'd0, 9'd0, 1'b1, BORDER_EXP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net: the run is a few thousand cycles.
    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
